// File: rtl/sm_dmem_arbiter_pkg.sv
// sm_dmem_arbiter_pkg: owner/mode encodings and helpers shared by the dmem arbiter slice.
package sm_dmem_arbiter_pkg;
   localparam logic ARB_M0    = 1'b0;
   localparam logic ARB_M1    = 1'b1;
   localparam logic ARB_RR    = 1'b0;
   localparam logic ARB_FIXED = 1'b1;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (&v) ? v : v + 16'd1;
   endfunction
endpackage

// File: rtl/sm_arb2_pick.sv
// sm_arb2_pick: pure two-way grant decision (round-robin or fixed m0 priority with forced m1).
module sm_arb2_pick
   import sm_dmem_arbiter_pkg::*;
(
   input  logic [1:0] req_i,
   input  logic       last_gnt_i,
   input  logic       force_m1_i,
   input  logic       mode_i,
   output logic [1:0] gnt_o
);
   logic m0_wins_tie;

   always_comb begin
      m0_wins_tie = (mode_i == ARB_FIXED) ? !force_m1_i : (last_gnt_i == ARB_M1);
      gnt_o[0]    = req_i[0] & (~req_i[1] | m0_wins_tie);
      gnt_o[1]    = req_i[1] & ~gnt_o[0];
   end
endmodule

// File: rtl/sm_dmem_arbiter.sv
// sm_dmem_arbiter: shares one single-port synchronous RAM between a CPU (m0) and a debug port (m1),
// steering 1-cycle read data back to its owner and counting contention cycles.
module sm_dmem_arbiter
   import sm_dmem_arbiter_pkg::*;
#(
   parameter int ADDR_W     = 6,
   parameter int DATA_W     = 32,
   parameter int PRIO_MODE  = 0,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              m0_req_i,
   input  logic              m0_we_i,
   input  logic [ADDR_W-1:0] m0_addr_i,
   input  logic [DATA_W-1:0] m0_wdata_i,
   output logic              m0_gnt_o,
   output logic              m0_rvalid_o,
   output logic [DATA_W-1:0] m0_rdata_o,
   input  logic              m1_req_i,
   input  logic              m1_we_i,
   input  logic [ADDR_W-1:0] m1_addr_i,
   input  logic [DATA_W-1:0] m1_wdata_i,
   output logic              m1_gnt_o,
   output logic              m1_rvalid_o,
   output logic [DATA_W-1:0] m1_rdata_o,
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic [15:0]       conflict_cnt_o
);
   localparam logic       MODE       = (PRIO_MODE != 0) ? ARB_FIXED : ARB_RR;
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   logic        last_gnt_q, last_gnt_d;
   logic [3:0]  starve_q, starve_d;
   logic        rd_pend_q, rd_pend_d;
   logic        rd_own_q, rd_own_d;
   logic [15:0] conflict_q, conflict_d;
   logic [1:0]  gnt;

   sm_arb2_pick u_pick (
      .req_i      ({m1_req_i, m0_req_i}),
      .last_gnt_i (last_gnt_q),
      .force_m1_i (starve_q == STARVE_LIM),
      .mode_i     (MODE),
      .gnt_o      (gnt)
   );

   always_comb begin
      m0_gnt_o       = gnt[0];
      m1_gnt_o       = gnt[1];
      mem_en_o       = |gnt;
      mem_we_o       = gnt[1] ? m1_we_i    : gnt[0] & m0_we_i;
      mem_addr_o     = gnt[1] ? m1_addr_i  : gnt[0] ? m0_addr_i  : '0;
      mem_wdata_o    = gnt[1] ? m1_wdata_i : gnt[0] ? m0_wdata_i : '0;
      last_gnt_d     = mem_en_o ? gnt[1] : last_gnt_q;
      starve_d       = (m1_req_i & ~gnt[1]) ? ((&starve_q) ? starve_q : starve_q + 4'd1) : 4'd0;
      rd_pend_d      = mem_en_o & ~mem_we_o;
      rd_own_d       = rd_pend_d ? gnt[1] : rd_own_q;
      conflict_d     = (m0_req_i & m1_req_i) ? sat_inc16(conflict_q) : conflict_q;
      m0_rvalid_o    = rd_pend_q & (rd_own_q == ARB_M0);
      m1_rvalid_o    = rd_pend_q & (rd_own_q == ARB_M1);
      m0_rdata_o     = m0_rvalid_o ? mem_rdata_i : '0;
      m1_rdata_o     = m1_rvalid_o ? mem_rdata_i : '0;
      conflict_cnt_o = conflict_q;
   end

   // last_gnt resets to m1 so m0 takes the first round-robin tie
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_gnt_q <= ARB_M1;
         starve_q   <= '0;
         rd_pend_q  <= 1'b0;
         rd_own_q   <= ARB_M0;
         conflict_q <= '0;
      end else begin
         last_gnt_q <= last_gnt_d;
         starve_q   <= starve_d;
         rd_pend_q  <= rd_pend_d;
         rd_own_q   <= rd_own_d;
         conflict_q <= conflict_d;
      end
   end
endmodule

// File: tb/tb_sm_dmem_arbiter.sv
// tb_sm_dmem_arbiter: round-robin and fixed-priority instances side by side, each with its own RAM,
// checked every cycle against a per-instance reference model.
module tb_sm_dmem_arbiter;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        r0 = 0, r1 = 0, w0 = 0, w1 = 0;
   logic [5:0]  a0 = 0, a1 = 0;
   logic [31:0] d0 = 0, d1 = 0;

   logic        g0 [2], g1 [2], v0 [2], v1 [2], men [2], mwe [2];
   logic [5:0]  madr [2];
   logic [31:0] rd0 [2], rd1 [2], mwd [2];
   logic [15:0] cc [2];

   int nv = 0, nerr = 0;

   bit          m_last [2];
   int          m_starve [2];
   int          m_cnt [2];
   bit          m_pv [2];
   bit          m_po [2];
   logic [31:0] m_pd [2];
   logic [31:0] m_mem [2][64];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : gen_dut
      logic [31:0] ram [64];
      logic [31:0] rq;
      sm_dmem_arbiter #(.ADDR_W(6), .DATA_W(32), .PRIO_MODE(g), .STARVE_MAX(4)) u_dut (
         .clk(clk), .rst_n(rst_n),
         .m0_req_i(r0), .m0_we_i(w0), .m0_addr_i(a0), .m0_wdata_i(d0),
         .m0_gnt_o(g0[g]), .m0_rvalid_o(v0[g]), .m0_rdata_o(rd0[g]),
         .m1_req_i(r1), .m1_we_i(w1), .m1_addr_i(a1), .m1_wdata_i(d1),
         .m1_gnt_o(g1[g]), .m1_rvalid_o(v1[g]), .m1_rdata_o(rd1[g]),
         .mem_en_o(men[g]), .mem_we_o(mwe[g]), .mem_addr_o(madr[g]), .mem_wdata_o(mwd[g]),
         .mem_rdata_i(rq), .conflict_cnt_o(cc[g])
      );
      always @(posedge clk)
         if (men[g]) begin
            if (mwe[g]) ram[madr[g]] <= mwd[g];
            else rq <= ram[madr[g]];
         end
   end

   task automatic chk(input string tag, input int d, input logic [31:0] o, input logic [31:0] e);
      nv++;
      assert (o === e) else begin
         nerr++;
         $error("FAIL %s dut%0d: got %0h expected %0h", tag, d, o, e);
      end
   endtask

   // One clock cycle with the currently driven inputs; the model states what the spec demands.
   task automatic cyc(input bit ck);
      bit          gv, win, rd_m0, rd_m1, we;
      logic [5:0]  ad;
      logic [31:0] wd;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         gv = r0 | r1;
         if (r0 && r1) win = (d == 0) ? !m_last[d] : (m_starve[d] == 4);
         else win = r1;
         we = win ? w1 : w0;
         ad = win ? a1 : a0;
         wd = win ? d1 : d0;
         rd_m0 = m_pv[d] && !m_po[d];
         rd_m1 = m_pv[d] && m_po[d];
         if (ck) begin
            chk("m0_gnt", d, 32'(g0[d]), 32'(gv && !win));
            chk("m1_gnt", d, 32'(g1[d]), 32'(gv && win));
            chk("mem_en", d, 32'(men[d]), 32'(gv));
            chk("mem_we", d, 32'(mwe[d]), 32'(gv && we));
            chk("mem_addr", d, 32'(madr[d]), gv ? 32'(ad) : 32'd0);
            chk("mem_wdata", d, mwd[d], gv ? wd : 32'd0);
            chk("m0_rvalid", d, 32'(v0[d]), 32'(rd_m0));
            chk("m1_rvalid", d, 32'(v1[d]), 32'(rd_m1));
            chk("m0_rdata", d, rd0[d], rd_m0 ? m_pd[d] : 32'd0);
            chk("m1_rdata", d, rd1[d], rd_m1 ? m_pd[d] : 32'd0);
            chk("conflict_cnt", d, 32'(cc[d]), 32'(m_cnt[d]));
         end
         if (r0 && r1 && m_cnt[d] < 65535) m_cnt[d]++;
         m_starve[d] = (r1 && !(gv && win)) ? m_starve[d] + 1 : 0;
         m_pv[d] = gv && !we;
         m_po[d] = win;
         m_pd[d] = m_mem[d][ad];
         if (gv && we) m_mem[d][ad] = wd;
         if (gv) m_last[d] = win;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      {r0, r1, w0, w1} = '0;
      a0 = 0; a1 = 0; d0 = 0; d1 = 0;
      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         m_last[d] = 1; m_starve[d] = 0; m_cnt[d] = 0; m_pv[d] = 0;
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("rst_m0_gnt", d, 32'(g0[d]), 32'd0);
         chk("rst_m1_gnt", d, 32'(g1[d]), 32'd0);
         chk("rst_m0_rvalid", d, 32'(v0[d]), 32'd0);
         chk("rst_m1_rvalid", d, 32'(v1[d]), 32'd0);
         chk("rst_m0_rdata", d, rd0[d], 32'd0);
         chk("rst_m1_rdata", d, rd1[d], 32'd0);
         chk("rst_mem_en", d, 32'(men[d]), 32'd0);
         chk("rst_mem_we", d, 32'(mwe[d]), 32'd0);
         chk("rst_mem_addr", d, 32'(madr[d]), 32'd0);
         chk("rst_mem_wdata", d, mwd[d], 32'd0);
         chk("rst_conflict_cnt", d, 32'(cc[d]), 32'd0);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      cyc(1);
   endtask

   initial begin
      do_reset();
      // preload every word through m0
      for (int a = 0; a < 64; a++) begin
         r0 = 1; w0 = 1; a0 = 6'(a); d0 = $urandom;
         cyc(1);
      end
      a0 = 5; d0 = 32'hA5A5A5A5;
      cyc(1);
      r0 = 0; w0 = 0;
      cyc(1);
      // lone m0 read of addr 5
      r0 = 1; a0 = 5;
      cyc(1);
      r0 = 0;
      cyc(1);
      cyc(1);
      // both masters reading continuously
      do_reset();
      r0 = 1; r1 = 1; w0 = 0; w1 = 0;
      for (int i = 0; i < 6; i++) begin
         a0 = 6'($urandom); a1 = 6'($urandom);
         cyc(1);
      end
      for (int d = 0; d < 2; d++) chk("six_conflicts", d, 32'(cc[d]), 32'd6);
      for (int i = 0; i < 10; i++) begin
         a0 = 6'($urandom); a1 = 6'($urandom);
         cyc(1);
      end
      // m1 write then m0 read of the same word
      r0 = 0; r1 = 0;
      cyc(1);
      r1 = 1; w1 = 1; a1 = 3; d1 = 32'h1234;
      cyc(1);
      r1 = 0; w1 = 0; r0 = 1; a0 = 3;
      cyc(1);
      r0 = 0;
      cyc(1);
      cyc(1);
      // reset while a read is in flight
      r0 = 1; w0 = 0; a0 = 7;
      cyc(1);
      do_reset();
      cyc(1);
      // randomized traffic on a narrow address range to force collisions
      for (int i = 0; i < 400; i++) begin
         r0 = 1'($urandom); r1 = 1'($urandom);
         w0 = 1'($urandom); w1 = 1'($urandom);
         a0 = 6'($urandom_range(0, 7)); a1 = 6'($urandom_range(0, 7));
         d0 = $urandom; d1 = $urandom;
         cyc(1);
      end
      // drive conflict_cnt to saturation
      do_reset();
      r0 = 1; r1 = 1; w0 = 0; w1 = 0;
      for (int i = 0; i < 65534; i++) cyc(0);
      for (int d = 0; d < 2; d++) chk("cnt_fffe", d, 32'(cc[d]), 32'h0000FFFE);
      for (int i = 0; i < 3; i++) cyc(1);
      for (int d = 0; d < 2; d++) chk("cnt_sat", d, 32'(cc[d]), 32'h0000FFFF);
      r0 = 0; r1 = 0;
      cyc(1);
      $display("== %0d vectors applied, %0d miscompares ==", nv, nerr);
      $finish;
   end
endmodule
